ip_lpm_scan: RTL and testbench

//  Parametrised longest-prefix-match engine for the router output_port_lookup

---
 rtl/ip_lpm_scan.sv | 211 +++++++++++++++++++++
 tb/tb_ip_lpm_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ip_lpm_scan.sv
// Longest-prefix-match lookup over a flop route table, scanned SCAN_PAR entries
// per cycle; returns next hop and output port plus register read/write access.

module ip_lpm_scan_lane (
   input  logic [31:0] key,
   input  logic [31:0] ip,
   input  logic [31:0] mask,
   input  logic        vld,
   output logic        match,
   output logic [5:0]  len
);
   always_comb begin
      len = '0;
      for (int b = 0; b < 32; b++) len = len + 6'(mask[b]);
   end
   assign match = vld && (((key ^ ip) & mask) == 32'd0);
endmodule

module ip_lpm_scan #(
   parameter int C_S_AXIS_DATA_WIDTH = 256,
   parameter int NUM_QUEUES          = 8,
   parameter int LUT_DEPTH           = 32,
   parameter int SCAN_PAR            = 4,
   parameter int DST_HI_LSB          = 240,
   parameter int DST_LO_LSB          = 0,
   parameter int DEFAULT_OQ          = 0,
   parameter int LUT_DEPTH_BITS      = $clog2(LUT_DEPTH)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0] tdata,
   input  logic                           word_IP_DST_HI,
   input  logic                           word_IP_DST_LO,
   output logic [31:0]                    next_hop_ip,
   output logic [NUM_QUEUES-1:0]          lpm_output_port,
   output logic                           lpm_vld,
   output logic                           lpm_hit,
   output logic                           lpm_drop,
   input  logic [LUT_DEPTH_BITS-1:0]      lpm_rd_addr,
   input  logic                           lpm_rd_req,
   output logic [31:0]                    lpm_rd_ip,
   output logic [31:0]                    lpm_rd_mask,
   output logic [31:0]                    lpm_rd_next_hop_ip,
   output logic [NUM_QUEUES-1:0]          lpm_rd_oq,
   output logic                           lpm_rd_vld,
   output logic                           lpm_rd_ack,
   input  logic [LUT_DEPTH_BITS-1:0]      lpm_wr_addr,
   input  logic                           lpm_wr_req,
   input  logic [31:0]                    lpm_wr_ip,
   input  logic [31:0]                    lpm_wr_mask,
   input  logic [31:0]                    lpm_wr_next_hop_ip,
   input  logic [NUM_QUEUES-1:0]          lpm_wr_oq,
   input  logic                           lpm_wr_vld,
   output logic                           lpm_wr_ack,
   output logic [31:0]                    hit_cnt,
   output logic [31:0]                    miss_cnt,
   output logic [31:0]                    drop_cnt
);
   localparam int G  = LUT_DEPTH / SCAN_PAR;
   localparam int GB = (G > 1) ? $clog2(G) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;
   state_t state, state_nxt;

   logic [LUT_DEPTH-1:0][31:0]            t_ip, t_mask, t_nh;
   logic [LUT_DEPTH-1:0][NUM_QUEUES-1:0]  t_oq;
   logic [LUT_DEPTH-1:0]                  t_vld;

   logic [31:0]               dst_ip, pend_key, key, new_key;
   logic                      pend_vld, do_wr, latch_key, fin, drop_now;
   logic [GB-1:0]             grp;
   logic                      b_hit, c_hit;
   logic [5:0]                b_len, c_len;
   logic [LUT_DEPTH_BITS-1:0] b_idx, c_idx;

   logic [SCAN_PAR-1:0]                     ln_match;
   logic [SCAN_PAR-1:0][5:0]                ln_len;
   logic [SCAN_PAR-1:0][LUT_DEPTH_BITS-1:0] ln_idx;

   generate
      for (genvar l = 0; l < SCAN_PAR; l++) begin : g_lane
         assign ln_idx[l] = LUT_DEPTH_BITS'(int'(grp) * SCAN_PAR + l);
         ip_lpm_scan_lane u_lane (
            .key   (key),
            .ip    (t_ip[ln_idx[l]]),
            .mask  (t_mask[ln_idx[l]]),
            .vld   (t_vld[ln_idx[l]]),
            .match (ln_match[l]),
            .len   (ln_len[l])
         );
      end
   endgenerate

   // strict '>' keeps the lowest index on equal prefix length
   always_comb begin
      c_hit = b_hit;
      c_len = b_len;
      c_idx = b_idx;
      for (int l = 0; l < SCAN_PAR; l++)
         if (ln_match[l] && (!c_hit || ln_len[l] > c_len)) begin
            c_hit = 1'b1;
            c_len = ln_len[l];
            c_idx = ln_idx[l];
         end
   end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!do_wr && pend_vld) state_nxt = SCAN;
         SCAN:    if (grp == GB'(G-1))    state_nxt = RESULT;
         default: state_nxt = IDLE;
      endcase
   end

   // wr_ack gate stops a still-held request from being taken twice
   always_comb begin
      do_wr     = (state == IDLE) && lpm_wr_req && !lpm_wr_ack;
      latch_key = (state == IDLE) && !do_wr && pend_vld;
      fin       = (state == SCAN) && (grp == GB'(G-1));
   end

   assign new_key  = {tdata[DST_LO_LSB +: 16],
                      word_IP_DST_HI ? tdata[DST_HI_LSB +: 16] : dst_ip[15:0]};
   assign drop_now = word_IP_DST_LO && pend_vld && !latch_key;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         dst_ip   <= '0;
         pend_vld <= 1'b0;
         pend_key <= '0;
         lpm_drop <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (word_IP_DST_HI) dst_ip[15:0]  <= tdata[DST_HI_LSB +: 16];
         if (word_IP_DST_LO) dst_ip[31:16] <= tdata[DST_LO_LSB +: 16];
         if (word_IP_DST_LO && (!pend_vld || latch_key)) begin
            pend_vld <= 1'b1;
            pend_key <= new_key;
         end else if (latch_key) pend_vld <= 1'b0;
         lpm_drop <= drop_now;
         if (drop_now) drop_cnt <= drop_cnt + 32'd1;
      end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         key <= '0; grp <= '0;
         b_hit <= 1'b0; b_len <= '0; b_idx <= '0;
      end else if (latch_key) begin
         key <= pend_key; grp <= '0;
         b_hit <= 1'b0; b_len <= '0; b_idx <= '0;
      end else if (state == SCAN) begin
         grp   <= fin ? '0 : grp + GB'(1);
         b_hit <= c_hit; b_len <= c_len; b_idx <= c_idx;
      end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         lpm_vld <= 1'b0; lpm_hit <= 1'b0;
         lpm_output_port <= '0; next_hop_ip <= '0;
         hit_cnt <= '0; miss_cnt <= '0;
      end else begin
         lpm_vld <= fin;
         if (fin) begin
            lpm_hit <= c_hit;
            if (c_hit) begin
               lpm_output_port <= t_oq[c_idx];
               next_hop_ip     <= (t_nh[c_idx] == 32'd0) ? key : t_nh[c_idx];
               hit_cnt         <= hit_cnt + 32'd1;
            end else begin
               lpm_output_port <= NUM_QUEUES'(DEFAULT_OQ);
               next_hop_ip     <= key;
               miss_cnt        <= miss_cnt + 32'd1;
            end
         end
      end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         t_ip <= '0; t_mask <= '0; t_nh <= '0; t_oq <= '0; t_vld <= '0;
         lpm_wr_ack <= 1'b0;
      end else begin
         lpm_wr_ack <= do_wr;
         if (do_wr) begin
            t_ip[lpm_wr_addr]   <= lpm_wr_ip;
            t_mask[lpm_wr_addr] <= lpm_wr_mask;
            t_nh[lpm_wr_addr]   <= lpm_wr_next_hop_ip;
            t_oq[lpm_wr_addr]   <= lpm_wr_oq;
            t_vld[lpm_wr_addr]  <= lpm_wr_vld;
         end
      end

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         lpm_rd_ack <= 1'b0; lpm_rd_ip <= '0; lpm_rd_mask <= '0;
         lpm_rd_next_hop_ip <= '0; lpm_rd_oq <= '0; lpm_rd_vld <= 1'b0;
      end else begin
         lpm_rd_ack <= lpm_rd_req;
         if (lpm_rd_req) begin
            lpm_rd_ip          <= t_ip[lpm_rd_addr];
            lpm_rd_mask        <= t_mask[lpm_rd_addr];
            lpm_rd_next_hop_ip <= t_nh[lpm_rd_addr];
            lpm_rd_oq          <= t_oq[lpm_rd_addr];
            lpm_rd_vld         <= t_vld[lpm_rd_addr];
         end
      end
endmodule

// File: tb/tb_ip_lpm_scan.sv
// Directed bench for ip_lpm_scan: route writes, LPM lookups, drops, mid-scan
// access and reset abort, with hand-computed expected values.

module tb_ip_lpm_scan;
   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [255:0] tdata = '0;
   logic         hi = 1'b0, lo = 1'b0;
   logic [31:0]  next_hop_ip;
   logic [7:0]   lpm_output_port;
   logic         lpm_vld, lpm_hit, lpm_drop;
   logic [4:0]   rd_addr = '0, wr_addr = '0;
   logic         rd_req = 1'b0, wr_req = 1'b0;
   logic [31:0]  rd_ip, rd_mask, rd_nh;
   logic [7:0]   rd_oq;
   logic         rd_vld, rd_ack;
   logic [31:0]  wr_ip = '0, wr_mask = '0, wr_nh = '0;
   logic [7:0]   wr_oq = '0;
   logic         wr_vld = 1'b0, wr_ack;
   logic [31:0]  hit_cnt, miss_cnt, drop_cnt;

   int checks = 0;
   int errors = 0;

   ip_lpm_scan dut (
      .clk(clk), .resetn(resetn), .tdata(tdata),
      .word_IP_DST_HI(hi), .word_IP_DST_LO(lo),
      .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port),
      .lpm_vld(lpm_vld), .lpm_hit(lpm_hit), .lpm_drop(lpm_drop),
      .lpm_rd_addr(rd_addr), .lpm_rd_req(rd_req),
      .lpm_rd_ip(rd_ip), .lpm_rd_mask(rd_mask), .lpm_rd_next_hop_ip(rd_nh),
      .lpm_rd_oq(rd_oq), .lpm_rd_vld(rd_vld), .lpm_rd_ack(rd_ack),
      .lpm_wr_addr(wr_addr), .lpm_wr_req(wr_req),
      .lpm_wr_ip(wr_ip), .lpm_wr_mask(wr_mask), .lpm_wr_next_hop_ip(wr_nh),
      .lpm_wr_oq(wr_oq), .lpm_wr_vld(wr_vld), .lpm_wr_ack(wr_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] ip, input logic [31:0] m,
                     input logic [7:0] oq, input logic [31:0] nh);
      int n;
      wr_addr = a; wr_ip = ip; wr_mask = m; wr_oq = oq; wr_nh = nh; wr_vld = 1'b1;
      wr_req = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!wr_ack && n < 30);
      wr_req = 1'b0;
      chk("wr_ack", 32'(wr_ack), 32'd1);
   endtask

   // leaves the bench one cycle after the LO strobe
   task automatic start_lu(input logic [31:0] ip);
      tdata = '0; tdata[255:240] = ip[15:0]; hi = 1'b1;
      tick();
      hi = 1'b0; tdata[15:0] = ip[31:16]; lo = 1'b1;
      tick();
      lo = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] ip, output int lat);
      start_lu(ip);
      lat = 1;
      while (!lpm_vld && lat < 30) begin tick(); lat++; end
   endtask

   initial begin
      int lat, nv, nd, vc, ac, vsum;
      logic [7:0] vport;

      tick(); tick();
      chk("rst_vld", 32'(lpm_vld), 0);
      chk("rst_hit", 32'(lpm_hit), 0);
      chk("rst_port", 32'(lpm_output_port), 0);
      chk("rst_nh", next_hop_ip, 0);
      chk("rst_cnt", hit_cnt | miss_cnt | drop_cnt, 0);
      chk("rst_acks", {29'd0, rd_ack, wr_ack, lpm_drop}, 0);
      resetn = 1'b1;
      tick();

      wr(5'd0, 32'h0A000000, 32'hFF000000, 8'h01, 32'h0);
      wr(5'd5, 32'h0A010000, 32'hFFFF0000, 8'h04, 32'h0A0100FE);
      lookup(32'h0A010203, lat);
      chk("lu1_lat", 32'(lat), 10);
      chk("lu1_hit", 32'(lpm_hit), 1);
      chk("lu1_port", 32'(lpm_output_port), 32'h04);
      chk("lu1_nh", next_hop_ip, 32'h0A0100FE);
      chk("lu1_hitcnt", hit_cnt, 1);
      tick();
      chk("vld_pulse", 32'(lpm_vld), 0);
      chk("hold_port", 32'(lpm_output_port), 32'h04);

      lookup(32'h0B000001, lat);
      chk("miss_lat", 32'(lat), 10);
      chk("miss_hit", 32'(lpm_hit), 0);
      chk("miss_port", 32'(lpm_output_port), 0);
      chk("miss_nh", next_hop_ip, 32'h0B000001);
      chk("miss_cnt", miss_cnt, 1);
      tick();

      wr(5'd31, 32'h0, 32'h0, 8'h80, 32'h0);
      lookup(32'h0B000001, lat);
      chk("dflt_hit", 32'(lpm_hit), 1);
      chk("dflt_port", 32'(lpm_output_port), 32'h80);
      chk("dflt_nh", next_hop_ip, 32'h0B000001);
      tick();
      lookup(32'h0A020000, lat);
      chk("p8_port", 32'(lpm_output_port), 32'h01);
      chk("p8_nh", next_hop_ip, 32'h0A020000);
      tick();

      wr(5'd3, 32'hC0A80100, 32'hFFFFFF00, 8'h02, 32'h0);
      wr(5'd9, 32'hC0A80100, 32'hFFFFFF00, 8'h08, 32'h0);
      lookup(32'hC0A80105, lat);
      chk("tie_port", 32'(lpm_output_port), 32'h02);
      chk("tie_nh", next_hop_ip, 32'hC0A80105);
      chk("tie_hitcnt", hit_cnt, 4);
      tick();

      tdata = '0; tdata[255:240] = 16'h0203; hi = 1'b1;
      tick();
      hi = 1'b0; tdata[15:0] = 16'h0A01; lo = 1'b1;
      tick(); tick(); tick();
      lo = 1'b0;
      nv = 0; nd = 0;
      for (int i = 0; i < 40; i++) begin
         nv += int'(lpm_vld); nd += int'(lpm_drop);
         tick();
      end
      chk("burst_results", 32'(nv), 2);
      chk("burst_drops", 32'(nd), 1);
      chk("drop_cnt", drop_cnt, 1);
      chk("burst_hitcnt", hit_cnt, 6);
      chk("burst_port", 32'(lpm_output_port), 32'h04);

      start_lu(32'h0A010203);
      tick(); tick();
      wr_addr = 5'd5; wr_ip = 32'h0A010000; wr_mask = 32'hFFFF0000;
      wr_oq = 8'h10; wr_nh = 32'h0; wr_vld = 1'b1; wr_req = 1'b1;
      rd_addr = 5'd5; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("mid_rd_ack", 32'(rd_ack), 1);
      chk("mid_rd_oq", 32'(rd_oq), 32'h04);
      chk("mid_rd_nh", rd_nh, 32'h0A0100FE);
      chk("mid_rd_mask", rd_mask, 32'hFFFF0000);
      chk("mid_rd_ip", rd_ip, 32'h0A010000);
      vc = 0; ac = 0; vport = '0;
      for (int i = 4; i < 30; i++) begin
         if (lpm_vld && vc == 0) begin vc = i; vport = lpm_output_port; end
         if (wr_ack && ac == 0) begin ac = i; wr_req = 1'b0; end
         tick();
      end
      wr_req = 1'b0;
      chk("mid_vld_cyc", 32'(vc), 10);
      chk("mid_ack_cyc", 32'(ac), 12);
      chk("mid_old_port", 32'(vport), 32'h04);
      lookup(32'h0A010203, lat);
      chk("new_port", 32'(lpm_output_port), 32'h10);
      chk("new_nh", next_hop_ip, 32'h0A010203);
      chk("pre_rst_hitcnt", hit_cnt, 8);
      tick();

      start_lu(32'h0A010203);
      tick(); tick(); tick();
      resetn = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      nv = 0;
      for (int i = 0; i < 20; i++) begin nv += int'(lpm_vld); tick(); end
      chk("abort_novld", 32'(nv), 0);
      chk("abort_cnt", hit_cnt | miss_cnt | drop_cnt, 0);
      vsum = 0;
      for (int a = 0; a < 32; a++) begin
         rd_addr = 5'(a); rd_req = 1'b1;
         tick();
         vsum += int'(rd_vld) + int'(!rd_ack);
      end
      rd_req = 1'b0;
      chk("abort_tbl_vld", 32'(vsum), 0);
      chk("abort_oq31", 32'(rd_oq), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
